// File: rtl/rx_byte_assembler_pkg.sv
// Shared widths, defaults and state encoding for the byte assembler.
// Also holds the single-bit shift helper used by the top FSM.
package rx_byte_assembler_pkg;

    localparam int BYTE_W    = 8;
    localparam int DEF_DEPTH = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } rx_state_e;

    // MSB-first shifts in at bit 0, LSB-first (UART) shifts in at bit 7.
    function automatic logic [BYTE_W-1:0] shift_in(
        input logic [BYTE_W-1:0] s,
        input logic              b,
        input logic              msb_first
    );
        if (msb_first)
            return {s[BYTE_W-2:0], b};
        else
            return {b, s[BYTE_W-1:1]};
    endfunction

endpackage

// File: rtl/rx_byte_assembler_if.sv
// Bit-stream input and byte-stream output of the receive assembler.
// master drives bits and consumes bytes; slave is the assembler.
interface rx_byte_assembler_if;
    import rx_byte_assembler_pkg::*;

    logic              rx_bit;
    logic              rx_valid;
    logic              rx_byte_start;
    logic [BYTE_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              frame_err;
    logic              overrun;
    logic              clr_overrun;

    modport master (
        output rx_bit,
        output rx_valid,
        output rx_byte_start,
        output dout_ready,
        output clr_overrun,
        input  dout,
        input  dout_valid,
        input  frame_err,
        input  overrun
    );

    modport slave (
        input  rx_bit,
        input  rx_valid,
        input  rx_byte_start,
        input  dout_ready,
        input  clr_overrun,
        output dout,
        output dout_valid,
        output frame_err,
        output overrun
    );

endinterface

// File: rtl/rx_byte_fifo.sv
// Small synchronous byte FIFO with a registered head-of-queue output.
// Pointers carry one extra wrap bit so full/empty come from the MSB.
module rx_byte_fifo
    import rx_byte_assembler_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic              clk_8mhz,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [BYTE_W-1:0] din,
    output logic              full,
    output logic              empty,
    output logic [BYTE_W-1:0] dout
);

    localparam int AW = $clog2(DEPTH);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [AW:0]       wr_nxt;
    logic [AW:0]       rd_nxt;
    logic              wr;
    logic              rd;
    logic [BYTE_W-1:0] head;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign rd = pop && !empty;
    assign wr = push && (!full || rd);

    assign wr_nxt = wr_ptr + {{AW{1'b0}}, wr};
    assign rd_nxt = rd_ptr + {{AW{1'b0}}, rd};

    // Head after this edge; a write landing on the new head means the
    // queue was drained, so the incoming byte bypasses storage.
    always_comb begin
        head = mem[rd_nxt[AW-1:0]];
        if (wr && (wr_ptr[AW-1:0] == rd_nxt[AW-1:0]))
            head = din;
    end

    // Storage write; contents need no reset since pointers gate them.
    always_ff @(posedge clk_8mhz) begin
        if (wr)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    // Pointer update and registered head byte.
    always_ff @(posedge clk_8mhz or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout   <= '0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            if (wr_nxt != rd_nxt)
                dout <= head;
        end
    end

endmodule

// File: rtl/rx_byte_assembler.sv
// Collects per-bit strobes from the bit-timing stage into bytes,
// queues them for the consumer and flags short frames and overruns.
module rx_byte_assembler
    import rx_byte_assembler_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int MSB_FIRST = 0
) (
    input  logic                clk_8mhz,
    input  logic                rst_n,
    rx_byte_assembler_if.slave  bus
);

    localparam logic MSBF = (MSB_FIRST != 0);

    rx_state_e         state;
    rx_state_e         state_n;
    logic [2:0]        bit_cnt;
    logic [2:0]        bit_cnt_n;
    logic [BYTE_W-1:0] shreg;
    logic [BYTE_W-1:0] shreg_n;
    logic [BYTE_W-1:0] shifted;
    logic              start_q;
    logic              start_rise;
    logic              ferr_n;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic              drop;

    assign start_rise = bus.rx_byte_start && !start_q;
    assign shifted    = shift_in(shreg, bus.rx_bit, MSBF);

    assign bus.dout_valid = !empty;
    assign pop            = !empty && bus.dout_ready;
    assign drop           = push && full && !pop;

    // Next state, shift data, completion push and short-frame flag.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        ferr_n    = 1'b0;
        push      = 1'b0;
        if (start_rise) begin
            state_n = ST_SHIFT;
            ferr_n  = (state == ST_SHIFT) && (bit_cnt != 3'd0);
            if (bus.rx_valid) begin
                shreg_n   = shift_in('0, bus.rx_bit, MSBF);
                bit_cnt_n = 3'd1;
            end else begin
                shreg_n   = '0;
                bit_cnt_n = 3'd0;
            end
        end else if ((state == ST_SHIFT) && bus.rx_valid) begin
            shreg_n = shifted;
            if (bit_cnt == 3'd7) begin
                push      = 1'b1;
                state_n   = ST_IDLE;
                bit_cnt_n = 3'd0;
            end else begin
                bit_cnt_n = bit_cnt + 3'd1;
            end
        end
    end

    // FSM, shift register, start edge history and error flags.
    always_ff @(posedge clk_8mhz or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            bit_cnt       <= 3'd0;
            shreg         <= '0;
            start_q       <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            state         <= state_n;
            bit_cnt       <= bit_cnt_n;
            shreg         <= shreg_n;
            start_q       <= bus.rx_byte_start;
            bus.frame_err <= ferr_n;
            if (drop)
                bus.overrun <= 1'b1;
            else if (bus.clr_overrun)
                bus.overrun <= 1'b0;
        end
    end

    rx_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_8mhz (clk_8mhz),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .din      (shifted),
        .full     (full),
        .empty    (empty),
        .dout     (bus.dout)
    );

endmodule
